mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter that shares the CPU's single-port data memory between the MEM pipeline stage and a bursting device port (DMA/loader). CPU gets priority per cycle, and the device may lock the memory for bounded bursts. The block drives the memory's address, write-data and write-enable lines and asserts a stall back to the pipeline while the CPU is locked out. Memory read is combinational from the address; memory write commits at posedge clk.

## Interface
- ADDR_W, 16, memory address width
- DATA_W, 16, memory data width
- BURST_MAX, 8, max device beats per lock (≥1)
- STARVE_LIMIT, 4, consecutive CPU wins before device is forced in (used only with macro)

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  MEM stage needs memory this cycle (load or store)
- cpu_wr  in  1  CPU access is a store
- cpu_addr  in  ADDR_W  CPU address (ALU result)
- cpu_wdata  in  DATA_W  CPU store data
- cpu_rdata  out  DATA_W  read data to MEM stage register (= mem_rdata)
- cpu_stall  out  1  CPU request not granted this cycle; pipeline holds
- dev_req  in  1  device requests a beat
- dev_wr  in  1  device beat is a write
- dev_addr  in  ADDR_W  device address
- dev_wdata  in  DATA_W  device write data
- dev_last  in  1  current device beat ends the burst
- dev_gnt  out  1  device beat accepted this cycle
- dev_rvalid  out  1  registered: read beat granted last cycle
- dev_rdata  out  DATA_W  registered read data for that beat
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  DATA_W  combinational memory read data

## Operation
- States: IDLE, DEV_BURST. Per-cycle grant decided combinationally from state and requests.
- IDLE: cpu_req=1 → CPU granted, unless starvation forcing is active (see Configuration). Else dev_req=1 → device granted. Else nothing granted.
- DEV_BURST: device owns memory. dev_gnt=dev_req. CPU never granted; cpu_stall=cpu_req.
- IDLE→DEV_BURST: device granted, dev_last=0, and beat count < BURST_MAX.
- DEV_BURST→IDLE on any one of: a granted beat with dev_last=1; dev_req=0 (abort, no beat); the granted beat is the BURST_MAX-th (forced release, treated as last).
- beat_cnt: set to 1 on first granted beat in IDLE, +1 per granted beat in DEV_BURST, cleared on return to IDLE.
- Mux: CPU granted → cpu_addr/cpu_wdata, mem_we=cpu_wr. Device granted → dev_* fields, mem_we=dev_wr. No grant → mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=0.
- cpu_stall = cpu_req & ~cpu_granted. cpu_rdata = mem_rdata at all times. It is valid when the CPU is granted and cpu_wr=0.
- dev_rvalid/dev_rdata: registered on posedge from (dev granted & ~dev_wr) and mem_rdata. dev_rdata holds its value when dev_rvalid=0.
- While rst=1: state=IDLE, beat_cnt=0, starve_cnt=0, dev_rvalid=0, dev_rdata=0. Outputs forced dev_gnt=0, mem_we=0, cpu_stall=0, mem_addr=cpu_addr, mem_wdata=cpu_wdata. Reset mid-burst aborts immediately; no beat completes.

## Timing
- CPU granted access: zero added latency. Read data appears the same cycle; a write commits at the next edge.
- Device read: dev_gnt in cycle N, dev_rvalid/dev_rdata in cycle N+1. Back-to-back beats give one rvalid per cycle.
- Forced release after BURST_MAX beats: the next cycle is arbitrated in IDLE, so a waiting CPU wins it.
- A CPU arriving during DEV_BURST stalls at most BURST_MAX cycles.
- dev_last=1 on a single beat in IDLE: granted, state stays IDLE.

## Configuration
- MEM_ARB_FAIRNESS_EN defined: starve_cnt (width to hold STARVE_LIMIT) increments on each IDLE cycle where dev_req=1 and the CPU is granted. It clears when the device is granted or dev_req=0. When starve_cnt==STARVE_LIMIT in IDLE, the device wins even with cpu_req=1 and the CPU stalls.
- Not defined: no starve_cnt. CPU has strict priority in IDLE, so the device can starve indefinitely.

## Test plan
- Reset with cpu_req=1, dev_req=1 → dev_gnt=0, mem_we=0, cpu_stall=0, dev_rvalid=0. Release reset: CPU granted on the first cycle.
- CPU store 0x00A5 to addr 3, then load addr 3 → mem_we=1 for one cycle, then cpu_rdata=0x00A5 with cpu_stall=0.
- Device 4-beat read burst from addr 8 (dev_last on beat 4), CPU requesting from beat 2 → cpu_stall=1 for 3 cycles. dev_rvalid is 1 for 4 cycles with data mem[8..11]. CPU is granted the cycle after beat 4.
- Device burst with dev_last never asserted, BURST_MAX=8, CPU waiting → release after 8 beats. CPU gets 1 cycle, then the device is re-granted if the CPU drops its request.
- Reset asserted on beat 2 of a burst → state IDLE, dev_gnt=0 immediately, no further writes.
- With MEM_ARB_FAIRNESS_EN, STARVE_LIMIT=4, both requesting continuously → CPU granted 4 cycles, then device granted 1 cycle with cpu_stall=1, pattern repeating. Without the macro, dev_gnt stays 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Shared-memory arbiter bus: CPU MEM-stage port, device burst port and memory port.
// slave = arbiter view, master = requesters/memory view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              dev_req;
  logic              dev_wr;
  logic [ADDR_W-1:0] dev_addr;
  logic [DATA_W-1:0] dev_wdata;
  logic              dev_last;
  logic              dev_gnt;
  logic              dev_rvalid;
  logic [DATA_W-1:0] dev_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  dev_req, dev_wr, dev_addr, dev_wdata, dev_last,
    input  mem_rdata,
    output cpu_rdata, cpu_stall, dev_gnt, dev_rvalid, dev_rdata,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output dev_req, dev_wr, dev_addr, dev_wdata, dev_last,
    output mem_rdata,
    input  cpu_rdata, cpu_stall, dev_gnt, dev_rvalid, dev_rdata,
    input  mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_arbiter.sv
// CPU/device arbiter for the single-port data memory; CPU has per-cycle priority.
// Define MEM_ARB_FAIRNESS_EN to force a device grant after STARVE_LIMIT CPU wins.
//
// state     | meaning
// IDLE      | per-cycle arbitration, CPU first
// DEV_BURST | device holds memory until last beat, abort or BURST_MAX beats
module mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int BURST_MAX    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  typedef enum logic {IDLE, DEV_BURST} state_t;

  localparam int CNT_W = $clog2(BURST_MAX + 1);

  state_t           state;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] beat_next;
  logic             cpu_gnt;
  logic             dev_gnt;
  logic             dev_force;
  logic             burst_end;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  logic [STARVE_W-1:0] starve_cnt;

  assign dev_force = (starve_cnt == STARVE_W'(STARVE_LIMIT)) && bus.dev_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (state == IDLE && bus.dev_req && cpu_gnt) begin
      starve_cnt <= starve_cnt + 1'b1;
    end else if (dev_gnt || !bus.dev_req) begin
      starve_cnt <= '0;
    end
  end
`else
  assign dev_force = 1'b0;
`endif

  always_comb begin
    cpu_gnt = 1'b0;
    dev_gnt = 1'b0;
    if (!rst) begin
      if (state == IDLE) begin
        if (bus.cpu_req && !dev_force) begin
          cpu_gnt = 1'b1;
        end else if (bus.dev_req) begin
          dev_gnt = 1'b1;
        end
      end else begin
        dev_gnt = bus.dev_req;
      end
    end
  end

  // beat_cnt is 0 in IDLE, so the same compare covers the first beat
  assign beat_next = beat_cnt + 1'b1;
  assign burst_end = bus.dev_last || (beat_next == CNT_W'(BURST_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dev_gnt && !burst_end) begin
            state    <= DEV_BURST;
            beat_cnt <= beat_next;
          end
        end
        DEV_BURST: begin
          if (!bus.dev_req || burst_end) begin
            state    <= IDLE;
            beat_cnt <= '0;
          end else begin
            beat_cnt <= beat_next;
          end
        end
        default: begin
          state    <= IDLE;
          beat_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.dev_rvalid <= 1'b0;
      bus.dev_rdata  <= '0;
    end else begin
      bus.dev_rvalid <= dev_gnt && !bus.dev_wr;
      if (dev_gnt && !bus.dev_wr) begin
        bus.dev_rdata <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_addr  = dev_gnt ? bus.dev_addr  : bus.cpu_addr;
  assign bus.mem_wdata = dev_gnt ? bus.dev_wdata : bus.cpu_wdata;
  assign bus.mem_we    = cpu_gnt ? bus.cpu_wr : (dev_gnt ? bus.dev_wr : 1'b0);
  assign bus.cpu_stall = bus.cpu_req && !cpu_gnt && !rst;
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.dev_gnt   = dev_gnt;
endmodule
